// File: rtl/lab2_pkg.sv
// Shared definitions for the lab2 counter link receiver: FSM states, step codes and
// the per-nibble Gray-to-binary decode.
package lab2_pkg;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ACQ   = 2'd1;
  localparam logic [1:0] S_LOCK  = 2'd2;

  localparam logic [1:0] STEP_HOLD = 2'd0;
  localparam logic [1:0] STEP_UP   = 2'd1;
  localparam logic [1:0] STEP_DOWN = 2'd2;
  localparam logic [1:0] STEP_ILL  = 2'd3;

  function automatic logic [3:0] gray4_to_bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/gray_track_decoder_if.sv
// Sample/decode bundle between the Gray counter link and the tracking decoder.
interface gray_track_decoder_if #(
  parameter int unsigned WRAP_W = 8
);
  logic              sample;
  logic [7:0]        gray_in;
  logic [7:0]        bin_out;
  logic              dir_up;
  logic              moving;
  logic              wrap;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              err;
  logic              locked;

  modport master (
    output sample, gray_in,
    input  bin_out, dir_up, moving, wrap, wrap_cnt, err, locked
  );

  modport slave (
    input  sample, gray_in,
    output bin_out, dir_up, moving, wrap, wrap_cnt, err, locked
  );
endinterface

// File: rtl/gray4_to_bin.sv
// Combinational 4-bit Gray to binary converter, one instance per nibble.
module gray4_to_bin (
  input  logic [3:0] gray,
  output logic [3:0] bin
);
  assign bin = lab2_pkg::gray4_to_bin(gray);
endmodule

// File: rtl/gray_track_decoder.sv
// Receive side of the lab2 up/down counter link: decodes nibble-wise Gray samples, checks
// each step is +1/-1/hold, tracks direction and wrap-arounds, and manages lock.
module gray_track_decoder
  import lab2_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned WRAP_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_track_decoder_if.slave  bus
);

  logic [3:0]        hi_bin, lo_bin;
  logic [7:0]        new_bin, diff;
  logic [1:0]        step;
  logic              is_up, is_down, is_ill;

  logic [1:0]        state_q, state_d;
  logic [3:0]        good_q, good_d;
  logic [7:0]        bin_q, bin_d;
  logic              dir_q, dir_d;
  logic              moving_q, moving_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              err_q, err_d;
  logic              locked_q, locked_d;

  gray4_to_bin u_hi (
    .gray (bus.gray_in[7:4]),
    .bin  (hi_bin)
  );

  gray4_to_bin u_lo (
    .gray (bus.gray_in[3:0]),
    .bin  (lo_bin)
  );

  assign new_bin = {hi_bin, lo_bin};
  assign diff    = new_bin - bin_q;

  always_comb begin
    step = STEP_ILL;
    if (diff == 8'h01)      step = STEP_UP;
    else if (diff == 8'hFF) step = STEP_DOWN;
    else if (diff == 8'h00) step = STEP_HOLD;
  end

  assign is_up   = (step == STEP_UP);
  assign is_down = (step == STEP_DOWN);
  assign is_ill  = (step == STEP_ILL);

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    bin_d      = bin_q;
    dir_d      = dir_q;
    moving_d   = 1'b0;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = 1'b0;

    if (bus.sample) begin
      // Always take the latest value so the reference resyncs after a glitch.
      bin_d    = new_bin;
      moving_d = is_up | is_down;
      if (is_up)   dir_d = 1'b1;
      if (is_down) dir_d = 1'b0;

      case (state_q)
        S_EMPTY: begin
          moving_d = 1'b0;
          dir_d    = dir_q;
          good_d   = 4'd0;
          state_d  = S_ACQ;
        end
        S_ACQ: begin
          if (is_ill) begin
            good_d = 4'd0;
          end else begin
            good_d = good_q + 4'd1;
            if (good_d == 4'(LOCK_CNT)) begin
              state_d = S_LOCK;
              good_d  = 4'd0;
            end
          end
        end
        S_LOCK: begin
          if (is_up && bin_q == 8'hFF) begin
            wrap_d     = 1'b1;
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
          end else if (is_down && bin_q == 8'h00) begin
            wrap_d     = 1'b1;
            wrap_cnt_d = wrap_cnt_q - WRAP_W'(1);
          end else if (is_ill) begin
            err_d   = 1'b1;
            good_d  = 4'd0;
            state_d = S_ACQ;
          end
        end
        default: begin
          good_d  = 4'd0;
          state_d = S_EMPTY;
        end
      endcase
    end

    locked_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      good_q     <= 4'd0;
      bin_q      <= 8'd0;
      dir_q      <= 1'b1;
      moving_q   <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      bin_q      <= bin_d;
      dir_q      <= dir_d;
      moving_q   <= moving_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.dir_up   = dir_q;
  assign bus.moving   = moving_q;
  assign bus.wrap     = wrap_q;
  assign bus.wrap_cnt = wrap_cnt_q;
  assign bus.err      = err_q;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_gray_track_decoder.sv
// Directed bench for gray_track_decoder (LOCK_CNT=4, WRAP_W=8) with immediate assertions.
module tb_gray_track_decoder;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  gray_track_decoder_if #(.WRAP_W(8)) bus ();

  gray_track_decoder #(
    .LOCK_CNT (4),
    .WRAP_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input logic [7:0] b);
    logic [3:0] h, l;
    h = b[7:4];
    l = b[3:0];
    return {h ^ (h >> 1), l ^ (l >> 1)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word at the negedge, let it be consumed, settle just after the edge.
  task automatic drive(input logic s, input logic [7:0] v);
    @(negedge clk);
    bus.sample  = s;
    bus.gray_in = enc(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    bus.sample = 1'b0;
    bus.gray_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin", bus.bin_out, 0);
    chk("rst_dir", bus.dir_up, 1);
    chk("rst_moving", bus.moving, 0);
    chk("rst_wrap", bus.wrap, 0);
    chk("rst_wcnt", bus.wrap_cnt, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_locked", bus.locked, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up sweep from 0 for 300 samples; one wrap at 255->0.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'(i));
      chk("up_bin", bus.bin_out, 32'(i % 256));
      chk("up_locked", bus.locked, (i >= 4) ? 1 : 0);
      chk("up_wrap", bus.wrap, (i == 256) ? 1 : 0);
      chk("up_err", bus.err, 0);
    end
    chk("up_wcnt", bus.wrap_cnt, 1);
    chk("up_dir", bus.dir_up, 1);
    chk("up_moving", bus.moving, 1);

    // Down from 43 to 2, then through zero.
    for (int v = 42; v >= 2; v--) drive(1'b1, 8'(v));
    chk("dn_dir", bus.dir_up, 0);
    chk("dn_locked", bus.locked, 1);
    drive(1'b1, 8'd1);
    drive(1'b1, 8'd0);
    chk("dn_nowrap", bus.wrap, 0);
    drive(1'b1, 8'd255);
    chk("dn_wrap", bus.wrap, 1);
    chk("dn_wcnt0", bus.wrap_cnt, 0);
    chk("dn_moving", bus.moving, 1);
    for (int v = 254; v >= 0; v--) begin
      drive(1'b1, 8'(v));
      chk("dn2_wrap", bus.wrap, 0);
    end
    drive(1'b1, 8'd255);
    chk("dn2_wrap_hit", bus.wrap, 1);
    chk("dn2_wcnt", bus.wrap_cnt, 32'hFF);

    // Hold and gap.
    drive(1'b1, 8'd255);
    chk("hold_moving", bus.moving, 0);
    chk("hold_dir", bus.dir_up, 0);
    chk("hold_err", bus.err, 0);
    chk("hold_wrap", bus.wrap, 0);
    chk("hold_locked", bus.locked, 1);
    drive(1'b0, 8'h5A);
    chk("gap_bin", bus.bin_out, 32'hFF);
    chk("gap_moving", bus.moving, 0);
    drive(1'b0, 8'h12);
    chk("gap_bin2", bus.bin_out, 32'hFF);
    chk("gap_err", bus.err, 0);
    chk("gap_wcnt", bus.wrap_cnt, 32'hFF);
    chk("gap_locked", bus.locked, 1);

    // Glitch at 0x20 -> 0x25, then reacquire.
    for (int v = 254; v >= 32; v--) drive(1'b1, 8'(v));
    chk("gl_pre_locked", bus.locked, 1);
    drive(1'b1, 8'h25);
    chk("gl_err", bus.err, 1);
    chk("gl_locked", bus.locked, 0);
    chk("gl_bin", bus.bin_out, 32'h25);
    chk("gl_moving", bus.moving, 0);
    drive(1'b1, 8'h26);
    chk("gl_err_pulse", bus.err, 0);
    drive(1'b1, 8'h27);
    drive(1'b1, 8'h28);
    chk("gl_acq_locked", bus.locked, 0);
    drive(1'b1, 8'h29);
    chk("gl_relock", bus.locked, 1);
    chk("gl_wcnt", bus.wrap_cnt, 32'hFF);

    // Nibble carry 0x0F -> 0x10.
    for (int v = 8'h28; v >= 8'h0F; v--) drive(1'b1, 8'(v));
    drive(1'b1, 8'h10);
    chk("nc_err", bus.err, 0);
    chk("nc_moving", bus.moving, 1);
    chk("nc_bin", bus.bin_out, 32'h10);
    chk("nc_dir", bus.dir_up, 1);
    chk("nc_locked", bus.locked, 1);

    // Asynchronous reset mid-stream, away from the clock edge.
    @(negedge clk);
    bus.sample  = 1'b1;
    bus.gray_in = enc(8'h11);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_bin", bus.bin_out, 0);
    chk("ar_dir", bus.dir_up, 1);
    chk("ar_wcnt", bus.wrap_cnt, 0);
    chk("ar_locked", bus.locked, 0);
    chk("ar_moving", bus.moving, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h80);
    chk("ar_reload", bus.bin_out, 32'h80);
    chk("ar_first_moving", bus.moving, 0);
    chk("ar_first_err", bus.err, 0);
    drive(1'b1, 8'h81);
    drive(1'b1, 8'h90);
    chk("acq_ill_err", bus.err, 0);
    chk("acq_ill_locked", bus.locked, 0);
    drive(1'b1, 8'h91);
    drive(1'b1, 8'h92);
    drive(1'b1, 8'h93);
    chk("acq_locked3", bus.locked, 0);
    drive(1'b1, 8'h94);
    chk("acq_locked4", bus.locked, 1);
    chk("acq_wcnt", bus.wrap_cnt, 0);

    bus.sample = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
